// File: rtl/vemicry_vlsu_pkg.sv
// Shared encodings for the VeMICry vector load/store sequencer:
// memory-op modes and FSM state codes.
package vemicry_vlsu_pkg;

    localparam logic [1:0] VLSU_LD  = 2'b00;
    localparam logic [1:0] VLSU_ST  = 2'b01;
    localparam logic [1:0] VLSU_BC  = 2'b10;
    localparam logic [1:0] VLSU_RSV = 2'b11;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_LOAD_DRAIN = 3'd2;
    localparam logic [2:0] S_STORE_RD   = 3'd3;
    localparam logic [2:0] S_STORE_WR   = 3'd4;
    localparam logic [2:0] S_BCAST_RD   = 3'd5;
    localparam logic [2:0] S_BCAST_WR   = 3'd6;
    localparam logic [2:0] S_DONE       = 3'd7;

endpackage

// File: rtl/vemicry_vlsu_agen.sv
// Element address generator: holds the running address and the count of
// accepted element requests, and flags when the current one is the last.
module vemicry_vlsu_agen
    import vemicry_vlsu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int VL_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [VL_W-1:0]   vl,
    output logic [ADDR_W-1:0] addr,
    output logic [VL_W-1:0]   cnt,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [VL_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        if (load) begin
            addr_d = base;
            cnt_d  = '0;
        end else if (step) begin
            // Two's-complement add wraps naturally for negative strides.
            addr_d = addr_q + stride;
            cnt_d  = cnt_q + VL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign addr = addr_q;
    assign cnt  = cnt_q;
    assign last = (cnt_q + VL_W'(1)) == vl;

endmodule

// File: rtl/vemicry_vlsu.sv
// Vector load/store sequencer: walks VL elements of one decoded vector memory
// op, moving data between data memory and the VRF while stalling the front end.
module vemicry_vlsu
    import vemicry_vlsu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int VLEN    = 8,
    parameter int VREG_N  = 8,
    localparam int IDX_W   = $clog2(VLEN),
    localparam int VL_W    = IDX_W + 1,
    localparam int VREG_AW = $clog2(VREG_N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [ADDR_W-1:0]  base_add,
    input  logic [ADDR_W-1:0]  stride,
    input  logic [VL_W-1:0]    vl,
    input  logic [VREG_AW-1:0] vreg_add,
    output logic               busy,
    output logic               done,
    output logic               pipe_stall,
    output logic               data_read,
    output logic               data_write,
    output logic [ADDR_W-1:0]  data_add,
    output logic [DATA_W-1:0]  data_in_mem,
    input  logic [DATA_W-1:0]  memdataout,
    input  logic               mem_ready,
    output logic               vrf_rd_en,
    output logic [VREG_AW-1:0] vrf_rd_add,
    output logic [IDX_W-1:0]   vrf_rd_index,
    input  logic [DATA_W-1:0]  vrf_rd_data,
    output logic               vrf_wr_en,
    output logic [VREG_AW-1:0] vrf_wr_add,
    output logic [IDX_W-1:0]   vrf_wr_index,
    output logic [DATA_W-1:0]  vrf_wr_data
);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  stride_q, stride_d;
    logic [VL_W-1:0]    vl_q, vl_d;
    logic [VL_W-1:0]    ret_cnt_q, ret_cnt_d;
    logic [VREG_AW-1:0] vreg_q, vreg_d;
    logic               pend_q, pend_d;
    logic [DATA_W-1:0]  hold_q, hold_d;

    logic               accept_start;
    logic [VL_W-1:0]    vl_clamped;
    logic               rd_req, wr_req, rd_en, wr_en, step;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  wr_data;
    logic [ADDR_W-1:0]  cur_add;
    logic [VL_W-1:0]    issue_cnt;
    logic               issue_last;

    vemicry_vlsu_agen #(
        .ADDR_W (ADDR_W),
        .VL_W   (VL_W)
    ) u_agen (
        .clock  (clock),
        .reset  (reset),
        .load   (accept_start),
        .step   (step),
        .base   (base_add),
        .stride (stride_q),
        .vl     (vl_q),
        .addr   (cur_add),
        .cnt    (issue_cnt),
        .last   (issue_last)
    );

    always_comb begin
        accept_start = (state_q == S_IDLE) && start;
        vl_clamped   = (vl > VL_W'(VLEN)) ? VL_W'(VLEN) : vl;
        state_d      = state_q;
        stride_d     = stride_q;
        vl_d         = vl_q;
        vreg_d       = vreg_q;
        hold_d       = hold_q;
        rd_req       = 1'b0;
        wr_req       = 1'b0;
        rd_en        = 1'b0;
        rd_idx       = '0;
        step         = 1'b0;
        wr_en        = pend_q;
        wr_data      = memdataout;
        pend_d       = (state_q == S_LOAD) && mem_ready;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    stride_d = stride;
                    vl_d     = vl_clamped;
                    vreg_d   = vreg_add;
                    if ((vl_clamped == '0) || (mode == VLSU_RSV)) begin
                        state_d = S_DONE;
                    end else if (mode == VLSU_LD) begin
                        state_d = S_LOAD;
                    end else if (mode == VLSU_ST) begin
                        state_d = S_STORE_RD;
                    end else begin
                        state_d = S_BCAST_RD;
                    end
                end
            end
            S_LOAD: begin
                rd_req = 1'b1;
                if (mem_ready) begin
                    step = 1'b1;
                    if (issue_last) state_d = S_LOAD_DRAIN;
                end
            end
            S_LOAD_DRAIN: state_d = S_DONE;
            S_STORE_RD: begin
                rd_en   = 1'b1;
                state_d = S_STORE_WR;
            end
            S_STORE_WR: begin
                wr_req = 1'b1;
                if (mem_ready) begin
                    step = 1'b1;
                    // Prefetch the next element so its data is ready next cycle.
                    if (issue_last) begin
                        state_d = S_DONE;
                    end else begin
                        rd_en  = 1'b1;
                        rd_idx = issue_cnt[IDX_W-1:0] + IDX_W'(1);
                    end
                end
            end
            S_BCAST_RD: begin
                rd_req = 1'b1;
                if (mem_ready) state_d = S_BCAST_WR;
            end
            S_BCAST_WR: begin
                wr_en = 1'b1;
                if (ret_cnt_q == '0) begin
                    hold_d = memdataout;
                end else begin
                    wr_data = hold_q;
                end
                if ((ret_cnt_q + VL_W'(1)) == vl_q) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept_start) begin
            ret_cnt_d = '0;
        end else if (wr_en) begin
            ret_cnt_d = ret_cnt_q + VL_W'(1);
        end else begin
            ret_cnt_d = ret_cnt_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            stride_q  <= '0;
            vl_q      <= '0;
            ret_cnt_q <= '0;
            vreg_q    <= '0;
            pend_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            stride_q  <= stride_d;
            vl_q      <= vl_d;
            ret_cnt_q <= ret_cnt_d;
            vreg_q    <= vreg_d;
            pend_q    <= pend_d;
            hold_q    <= hold_d;
        end
    end

    // Outputs are forced low while reset is high so a read returning in the
    // reset cycle can never reach the VRF.
    assign busy         = (state_q != S_IDLE) && !reset;
    assign done         = (state_q == S_DONE) && !reset;
    assign pipe_stall   = start || (!reset && (state_q != S_IDLE) && (state_q != S_DONE));
    assign data_read    = rd_req && !reset;
    assign data_write   = wr_req && !reset;
    assign data_add     = (data_read || data_write) ? cur_add : '0;
    assign data_in_mem  = data_write ? vrf_rd_data : '0;
    assign vrf_rd_en    = rd_en && !reset;
    assign vrf_rd_add   = vrf_rd_en ? vreg_q : '0;
    assign vrf_rd_index = vrf_rd_en ? rd_idx : '0;
    assign vrf_wr_en    = wr_en && !reset;
    assign vrf_wr_add   = vrf_wr_en ? vreg_q : '0;
    assign vrf_wr_index = vrf_wr_en ? ret_cnt_q[IDX_W-1:0] : '0;
    assign vrf_wr_data  = vrf_wr_en ? wr_data : '0;

endmodule

// File: tb/tb_vemicry_vlsu.sv
// Scoreboard bench for vemicry_vlsu: a behavioural op model fills expectation
// queues; a monitor pops them as memory/VRF/done events appear on the DUT.
module tb_vemicry_vlsu;

    localparam int DATA_W = 32, ADDR_W = 16, VLEN = 8, VREG_N = 8;
    localparam int IDX_W = 3, VL_W = 4, VREG_AW = 3;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [ADDR_W-1:0]  base_add = '0;
    logic [ADDR_W-1:0]  stride = '0;
    logic [VL_W-1:0]    vl = '0;
    logic [VREG_AW-1:0] vreg_add = '0;
    logic               busy, done, pipe_stall, data_read, data_write;
    logic [ADDR_W-1:0]  data_add;
    logic [DATA_W-1:0]  data_in_mem;
    logic [DATA_W-1:0]  memdataout;
    logic               mem_ready;
    logic               vrf_rd_en;
    logic [VREG_AW-1:0] vrf_rd_add;
    logic [IDX_W-1:0]   vrf_rd_index;
    logic [DATA_W-1:0]  vrf_rd_data;
    logic               vrf_wr_en;
    logic [VREG_AW-1:0] vrf_wr_add;
    logic [IDX_W-1:0]   vrf_wr_index;
    logic [DATA_W-1:0]  vrf_wr_data;

    vemicry_vlsu #(
        .DATA_W (DATA_W), .ADDR_W (ADDR_W), .VLEN (VLEN), .VREG_N (VREG_N)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .base_add     (base_add),
        .stride       (stride),
        .vl           (vl),
        .vreg_add     (vreg_add),
        .busy         (busy),
        .done         (done),
        .pipe_stall   (pipe_stall),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_add     (data_add),
        .data_in_mem  (data_in_mem),
        .memdataout   (memdataout),
        .mem_ready    (mem_ready),
        .vrf_rd_en    (vrf_rd_en),
        .vrf_rd_add   (vrf_rd_add),
        .vrf_rd_index (vrf_rd_index),
        .vrf_rd_data  (vrf_rd_data),
        .vrf_wr_en    (vrf_wr_en),
        .vrf_wr_add   (vrf_wr_add),
        .vrf_wr_index (vrf_wr_index),
        .vrf_wr_data  (vrf_wr_data)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
    } mem_t;

    typedef struct packed {
        logic [2:0]  vreg;
        logic [2:0]  idx;
        logic [31:0] data;
    } vrf_t;

    mem_t        exp_mem[$];
    vrf_t        exp_vrf[$];
    int          exp_done[$];
    logic [31:0] mem_a[logic [15:0]];
    logic [31:0] vrf_m[8][8];
    int          n_chk = 0, n_pass = 0;
    int          win_lo = 1, busy_hi = 0, stall_hi = 0;
    int          stall_pat[9];
    int          op_id = 0;

    function automatic logic [31:0] mem_rd(logic [15:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return {a, ~a} ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] all_outs();
        return {29'd0, busy, done, pipe_stall, data_read, data_write, data_add, data_in_mem,
                vrf_rd_en, vrf_rd_add, vrf_rd_index, vrf_wr_en, vrf_wr_add,
                vrf_wr_index, vrf_wr_data};
    endfunction

    task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Memory and VRF read ports as the DUT sees them.
    always @(posedge clock) begin
        if (data_read && mem_ready) memdataout <= mem_rd(data_add);
        else                        memdataout <= $urandom;
        if (vrf_rd_en) vrf_rd_data <= vrf_m[vrf_rd_add][vrf_rd_index];
    end

    // mem_ready follows a per-op stall pattern: stall_pat[j] refusals before accept j.
    int seen_op = 0, acc_idx = 0, stall_left = 0;
    always begin : ready_drv
        @(negedge clock);
        #1;
        if (op_id != seen_op) begin
            seen_op    = op_id;
            acc_idx    = 0;
            stall_left = stall_pat[0];
        end
        if (data_read || data_write) begin
            if (stall_left > 0) begin
                mem_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                mem_ready  = 1'b1;
                if (acc_idx < 8) acc_idx = acc_idx + 1;
                stall_left = stall_pat[acc_idx];
            end
        end else begin
            mem_ready = 1'($urandom_range(0, 1));
        end
    end

    always begin : monitor
        logic busy_exp, stall_exp;
        mem_t m_got, m_exp;
        vrf_t v_got, v_exp;
        @(negedge clock);
        #2;
        busy_exp  = !reset && (cyc >= win_lo) && (cyc <= busy_hi);
        stall_exp = start || (!reset && (cyc >= win_lo) && (cyc <= stall_hi));
        check("ctl", {124'd0, data_read & data_write,
                      !(data_read | data_write) && (data_add != 0), busy, pipe_stall},
              {126'd0, busy_exp, stall_exp});
        if ((data_read || data_write) && mem_ready) begin
            m_got = {data_write, data_add, data_write ? data_in_mem : 32'd0};
            if (exp_mem.size() == 0) begin
                check("mem_req_extra", 128'(m_got), 128'd0);
            end else begin
                m_exp = exp_mem.pop_front();
                check("mem_req", 128'(m_got), 128'(m_exp));
                if (m_exp.wr) mem_a[m_exp.addr] = m_exp.wdata;
            end
        end
        if (vrf_wr_en) begin
            v_got = {vrf_wr_add, vrf_wr_index, vrf_wr_data};
            if (exp_vrf.size() == 0) begin
                check("vrf_wr_extra", 128'(v_got), 128'd0);
            end else begin
                v_exp = exp_vrf.pop_front();
                check("vrf_wr", 128'(v_got), 128'(v_exp));
            end
        end
        if (done) begin
            if (exp_done.size() == 0) check("done_extra", 128'd1, 128'd0);
            else                      check("done_cycle", 128'(cyc), 128'(exp_done.pop_front()));
        end
    end

    task automatic set_stalls(bit rnd);
        for (int j = 0; j < 9; j++) stall_pat[j] = rnd ? $urandom_range(0, 2) : 0;
    endtask

    task automatic run_op(logic [1:0] m, logic [15:0] b, logic [15:0] s,
                          logic [3:0] v, logic [2:0] r, bit stray);
        int vl_eff, nacc, dly, n, d;
        bit zero_op;
        logic [15:0] a;
        vl_eff  = (v > 4'd8) ? 8 : int'(v);
        zero_op = (vl_eff == 0) || (m == 2'b11);
        nacc    = 0;
        dly     = 0;
        if (!zero_op) begin
            for (int i = 0; i < vl_eff; i++) begin
                a = b + 16'(i) * s;
                if (m == 2'b00) begin
                    exp_mem.push_back({1'b0, a, 32'd0});
                    exp_vrf.push_back({r, 3'(i), mem_rd(a)});
                end else if (m == 2'b01) begin
                    exp_mem.push_back({1'b1, a, vrf_m[r][i]});
                end else begin
                    if (i == 0) exp_mem.push_back({1'b0, b, 32'd0});
                    exp_vrf.push_back({r, 3'(i), mem_rd(b)});
                end
            end
            nacc = (m == 2'b10) ? 1 : vl_eff;
        end
        for (int j = 0; j < nacc; j++) dly += stall_pat[j];
        @(negedge clock);
        mode = m; base_add = b; stride = s; vl = v; vreg_add = r; start = 1'b1;
        n = cyc;
        d = zero_op ? n + 1 : n + vl_eff + 2 + dly;
        exp_done.push_back(d);
        win_lo = n + 1; busy_hi = d; stall_hi = d - 1;
        op_id++;
        $display("op %0d: mode=%0d base=%h stride=%h vl=%0d vreg=%0d stalls=%0d done_at=%0d",
                 op_id, m, b, s, v, r, dly, d);
        @(negedge clock);
        start = 1'b0;
        mode = 2'($urandom); base_add = 16'($urandom); stride = 16'($urandom);
        vl = 4'($urandom); vreg_add = 3'($urandom);
        if (stray && !zero_op) begin
            @(negedge clock);
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        for (int k = 0; k < 400 && exp_done.size() != 0; k++) begin
            @(negedge clock);
            #3;
        end
        if (exp_done.size() != 0) begin
            check("done_timeout", 128'd1, 128'd0);
            exp_done.delete(); exp_mem.delete(); exp_vrf.delete();
        end
        check("op_drain", 128'({exp_mem.size(), exp_vrf.size()}), 128'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [15:0] b;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++) vrf_m[i][j] = $urandom;
        vrf_m[2][0] = 32'hAAAA_000A; vrf_m[2][1] = 32'hBBBB_000B;
        vrf_m[2][2] = 32'hCCCC_000C; vrf_m[2][3] = 32'hDDDD_000D;
        mem_a[16'h0040] = 32'hDEAD_BEEF;
        set_stalls(0);

        // Reset state, and pipe_stall tracking start while in reset.
        repeat (3) @(negedge clock);
        #3;
        check("reset_outs", all_outs(), 128'd0);
        start = 1'b1;
        #1;
        check("reset_stall", 128'(pipe_stall), 128'd1);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;

        run_op(2'b00, 16'h0100, 16'h0004, 4'd8, 3'd1, 0);
        run_op(2'b01, 16'h0200, 16'hFFFC, 4'd4, 3'd2, 0);
        run_op(2'b10, 16'h0040, 16'h1234, 4'd5, 3'd3, 0);
        stall_pat[1] = 2;
        run_op(2'b00, 16'h0300, 16'h0010, 4'd3, 3'd4, 0);
        set_stalls(0);
        run_op(2'b00, 16'h0400, 16'h0004, 4'd0, 3'd5, 0);
        run_op(2'b11, 16'h0500, 16'h0004, 4'd5, 3'd5, 0);
        run_op(2'b00, 16'h0600, 16'h0008, 4'd12, 3'd6, 0);
        run_op(2'b00, 16'hFFFE, 16'h0002, 4'd3, 3'd7, 1);
        run_op(2'b01, 16'h0010, 16'h0004, 4'd8, 3'd0, 1);

        // Reset after three accepted reads: only the first two reads reach the VRF.
        b = 16'h0800;
        for (int i = 0; i < 3; i++) exp_mem.push_back({1'b0, b + 16'(i * 4), 32'd0});
        for (int i = 0; i < 2; i++) exp_vrf.push_back({3'd1, 3'(i), mem_rd(b + 16'(i * 4))});
        @(negedge clock);
        mode = 2'b00; base_add = b; stride = 16'd4; vl = 4'd8; vreg_add = 3'd1; start = 1'b1;
        n = cyc;
        win_lo = n + 1; busy_hi = n + 3; stall_hi = n + 3;
        op_id++;
        $display("op %0d: load base=%h vl=8 with reset after 3 accepts", op_id, b);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #3;
        check("rst_mid_outs", all_outs(), 128'd0);
        @(negedge clock);
        reset = 1'b0;
        #3;
        check("rst_after_outs", all_outs(), 128'd0);
        check("rst_drain", 128'({exp_mem.size(), exp_vrf.size()}), 128'd0);
        exp_mem.delete(); exp_vrf.delete();

        run_op(2'b00, 16'h0900, 16'h0004, 4'd6, 3'd1, 0);

        for (int t = 0; t < 40; t++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            set_stalls($urandom_range(0, 1) == 1);
            run_op(m, 16'($urandom), ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'(4),
                   4'($urandom_range(0, 15)), 3'($urandom), $urandom_range(0, 1) == 1);
        end

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vemicry_vlsu.md
Name: vemicry_vlsu

Overview:
- Parametrised vector load/store sequencer for the VeMICry pipeline.
- Accepts one decoded vector memory op per start pulse and walks VL elements.
- Issues element-wise memory requests (strided or scalar-broadcast), moving data between data memory and the vector register file (VRF).
- Stalls the front end via pipe_stall until the op completes.

Parameters:
- DATA_W, 32: element and memory data width.
- ADDR_W, 16: memory address width.
- VLEN, 8: maximum elements per vector register (power of 2, ≥2).
- VREG_N, 8: number of vector registers (power of 2).
- Derived localparams: IDX_W=clog2(VLEN), VL_W=IDX_W+1, VREG_AW=clog2(VREG_N).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  op valid, one-cycle pulse from ID; ignored while busy.
- mode  in  2  00 strided load, 01 strided store, 10 broadcast load, 11 reserved.
- base_add  in  ADDR_W  first element address (from rs).
- stride  in  ADDR_W  two's-complement element stride (from rt).
- vl  in  VL_W  vector length, 0..VLEN; values >VLEN clamp to VLEN.
- vreg_add  in  VREG_AW  VRF register operand.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- pipe_stall  out  1  start | (state not in {IDLE, DONE}); combinational.
- data_read  out  1  memory read request.
- data_write  out  1  memory write request.
- data_add  out  ADDR_W  request address.
- data_in_mem  out  DATA_W  store data to memory.
- memdataout  in  DATA_W  read data, valid exactly 1 cycle after an accepted read.
- mem_ready  in  1  request accepted when data_read|data_write & mem_ready.
- vrf_rd_en  out  1  VRF read; data valid next cycle, held until next vrf_rd_en.
- vrf_rd_add  out  VREG_AW  VRF read register.
- vrf_rd_index  out  IDX_W  VRF read element index.
- vrf_rd_data  in  DATA_W  VRF read data.
- vrf_wr_en  out  1  VRF write strobe.
- vrf_wr_add  out  VREG_AW  VRF write register.
- vrf_wr_index  out  IDX_W  VRF write element index.
- vrf_wr_data  out  DATA_W  VRF write data.

Behaviour:
- Reset (any cycle, including mid-op):
  - state→IDLE, counters and address cleared.
  - All outputs 0; pipe_stall follows start.
  - A read accepted in the cycle before reset is discarded: no VRF write after reset.
- Start acceptance:
  - Sampled only in IDLE.
  - Latches mode, base, stride, clamped vl and vreg_add into op registers.
  - Later input changes have no effect on the running op.
- States: IDLE, LOAD, LOAD_DRAIN, STORE_RD, STORE_WR, BCAST_RD, BCAST_WR, DONE.
- IDLE → DONE when start is sampled with vl=0 or mode=11. No memory or VRF access occurs.
- Strided load (LOAD):
  - Each cycle with issue_cnt<vl: data_read=1, data_add=cur_add.
  - On acceptance: cur_add += stride (mod 2^ADDR_W), issue_cnt++.
  - Registered pending flag: the cycle after an acceptance, vrf_wr_en=1, vrf_wr_data=memdataout, vrf_wr_index=ret_cnt, then ret_cnt++.
  - The last acceptance moves the FSM to LOAD_DRAIN (final write only), then DONE.
- Strided store:
  - STORE_RD: vrf_rd_en=1 for index 0, then STORE_WR.
  - STORE_WR: data_write=1, data_in_mem=vrf_rd_data. The request is held while mem_ready=0.
  - On acceptance with elements remaining: vrf_rd_en for the next index in the same cycle, stride add, stay in STORE_WR.
  - Acceptance of the last element moves the FSM to DONE.
- Broadcast load:
  - BCAST_RD: one data_read at base_add, held until accepted.
  - BCAST_WR: the first cycle captures memdataout into a hold register and writes it to element 0. Later cycles write the hold register to elements 1..vl-1, one per cycle; stride is ignored.
  - Last write → DONE.
- DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is not accepted.
- Latency: with mem_ready tied high and start sampled at cycle T, done asserts at T+vl+2 for all three modes. Each mem_ready=0 cycle adds exactly one cycle.
- data_read and data_write are never both high. data_add is 0 when neither is high.
- Address wrap: 16'hFFFE+2 → 16'h0000; negative strides are allowed.

Decomposition:
- Shared include instruction_set.v gains:
  - VLSU mode encodings (VLSU_LD, VLSU_ST, VLSU_BC, VLSU_RSV).
  - State encodings as localparam-style defines.
- One sub-module, vemicry_vlsu_agen, holds:
  - the address register (load base, add stride on step);
  - the issue counter and last-element compare.

Test Plan:
- Strided load, base=0x0100, stride=4, vl=8, mem_ready=1 → reads at 0x100..0x11C; VRF writes idx0..7 with returned data; done at T+10.
- Strided store, base=0x0200, stride=-4 (0xFFFC), vl=4, VRF {A,B,C,D} → writes A@0x200, B@0x1FC, C@0x1F8, D@0x1F4; done at T+6.
- Broadcast load, base=0x0040, mem[0x40]=0xDEADBEEF, vl=5 → exactly one read; VRF idx0..4 = 0xDEADBEEF; done at T+7.
- Load vl=3, mem_ready=0 on 2nd and 3rd request cycles → data_add held at the same address; 3 writes, no duplicates; done at T+7.
- Corner inputs:
  - vl=0 → done at T+1, no reads or writes.
  - mode=11 → same response.
  - vl=12 with VLEN=8 → exactly 8 accesses.
- Start pulse while busy → ignored.
- Reset asserted mid-load after 3 accepts → next cycle all outputs 0, no VRF write; a new op then runs correctly from idx0.
